// File: rtl/bus_arbiter.sv
// Shared coherence/RAM bus arbiter: data class over instruction class, per-class
// round-robin, instruction aging against starvation, grant held until done/abort.
module bus_arbiter #(
    parameter int unsigned CACHE_W    = 2,
    parameter int unsigned STARVE_MAX = 8,
    localparam int unsigned ID_W      = (CACHE_W > 1) ? $clog2(CACHE_W) : 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [CACHE_W-1:0] dREN,
    input  logic [CACHE_W-1:0] dWEN,
    input  logic [CACHE_W-1:0] iREN,
    input  logic               done,
    output logic [CACHE_W-1:0] dgnt,
    output logic [CACHE_W-1:0] ignt,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_DATA  = 2'd1;
    localparam logic [1:0] ARB_INSTR = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic [CACHE_W-1:0]  dgnt_q,   dgnt_d;
    logic [CACHE_W-1:0]  ignt_q,   ignt_d;
    logic                valid_q,  valid_d;
    logic [ID_W-1:0]     id_q,     id_d;
    logic [ID_W-1:0]     dptr_q,   dptr_d;
    logic [ID_W-1:0]     iptr_q,   iptr_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic [CACHE_W-1:0]  dreq_c;
    logic [ID_W-1:0]     dwin_c, iwin_c;
    logic                dfound_c, ifound_c;
    int unsigned         di_c, ii_c;

    assign dreq_c = dREN | dWEN;

    // Round-robin search of each class, starting at its own pointer and wrapping
    always_comb begin
        dwin_c   = '0;
        iwin_c   = '0;
        dfound_c = 1'b0;
        ifound_c = 1'b0;
        di_c     = 0;
        ii_c     = 0;
        for (int unsigned off = 0; off < CACHE_W; off++) begin
            di_c = (32'(dptr_q) + off) % CACHE_W;
            ii_c = (32'(iptr_q) + off) % CACHE_W;
            if (!dfound_c && ((dreq_c >> di_c) & CACHE_W'(1)) != '0) begin
                dfound_c = 1'b1;
                dwin_c   = ID_W'(di_c);
            end
            if (!ifound_c && ((iREN >> ii_c) & CACHE_W'(1)) != '0) begin
                ifound_c = 1'b1;
                iwin_c   = ID_W'(ii_c);
            end
        end
    end

    // Next-state: arbitrate in IDLE, hold grant until done or the owner drops its request
    always_comb begin
        state_d  = state_q;
        dgnt_d   = dgnt_q;
        ignt_d   = ignt_q;
        valid_d  = valid_q;
        id_d     = id_q;
        dptr_d   = dptr_q;
        iptr_d   = iptr_q;
        starve_d = starve_q;
        unique case (state_q)
            ARB_IDLE: begin
                if ((starve_q == STARVE_W'(STARVE_MAX) && ifound_c) || (!dfound_c && ifound_c)) begin
                    state_d  = ARB_INSTR;
                    ignt_d   = CACHE_W'(1) << iwin_c;
                    valid_d  = 1'b1;
                    id_d     = iwin_c;
                    iptr_d   = ID_W'((32'(iwin_c) + 1) % CACHE_W);
                    starve_d = '0;
                end else if (dfound_c) begin
                    state_d = ARB_DATA;
                    dgnt_d  = CACHE_W'(1) << dwin_c;
                    valid_d = 1'b1;
                    id_d    = dwin_c;
                    dptr_d  = ID_W'((32'(dwin_c) + 1) % CACHE_W);
                    if (!ifound_c) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
            ARB_DATA, ARB_INSTR: begin
                // done has priority; abort when the owner's request of its class falls
                if (done || (state_q == ARB_DATA  && (dreq_c & dgnt_q) == '0)
                         || (state_q == ARB_INSTR && (iREN   & ignt_q) == '0)) begin
                    state_d = ARB_IDLE;
                    dgnt_d  = '0;
                    ignt_d  = '0;
                    valid_d = 1'b0;
                    id_d    = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                dgnt_d  = '0;
                ignt_d  = '0;
                valid_d = 1'b0;
                id_d    = '0;
            end
        endcase
    end

    // State and grant registers; async reset drops grants immediately
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ARB_IDLE;
            dgnt_q   <= '0;
            ignt_q   <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            dptr_q   <= '0;
            iptr_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            dgnt_q   <= dgnt_d;
            ignt_q   <= ignt_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            dptr_q   <= dptr_d;
            iptr_q   <= iptr_d;
            starve_q <= starve_d;
        end
    end

    assign dgnt        = dgnt_q;
    assign ignt        = ignt_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, corner sequences, random vs. model.
module tb_bus_arbiter;

    localparam int N  = 2;
    localparam int SM = 4;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [1:0] dREN, dWEN, iREN;
    logic       done;
    logic [1:0] dgnt, ignt;
    logic       grant_valid;
    logic [0:0] grant_id;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.CACHE_W(N), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .iREN(iREN), .done(done),
        .dgnt(dgnt), .ignt(ignt), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] dr, dw, ir;
        logic       dn;
        logic [1:0] ed, ei;
        logic       eid;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic [1:0] dr, logic [1:0] dw, logic [1:0] ir, logic dn,
                                logic [1:0] ed, logic [1:0] ei, logic eid);
        vec_t v;
        v.dr = dr; v.dw = dw; v.ir = ir; v.dn = dn; v.ed = ed; v.ei = ei; v.eid = eid;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic invariants();
        logic [3:0] all;
        int         id;
        all = {dgnt, ignt};
        id  = 0;
        for (int k = 0; k < N; k++) if (dgnt[k] || ignt[k]) id = k;
        chk("onehot", 32'($countones(all) <= 1), 32'd1);
        chk("valid_or", 32'(grant_valid), 32'(all != 4'b0));
        chk("id_match", 32'(grant_id), 32'(id));
    endtask

    // Apply inputs at a falling edge, step one cycle, land on the next falling edge
    task automatic cyc(input logic [1:0] dr, input logic [1:0] dw, input logic [1:0] ir, input logic dn);
        dREN = dr; dWEN = dw; iREN = ir; done = dn;
        @(negedge CLK);
        invariants();
    endtask

    task automatic expect_out(input string nm, input logic [1:0] ed, input logic [1:0] ei, input logic eid);
        chk({nm, "_dgnt"}, 32'(dgnt), 32'(ed));
        chk({nm, "_ignt"}, 32'(ignt), 32'(ei));
        chk({nm, "_id"},   32'(grant_id), 32'(eid));
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        dREN = '0; dWEN = '0; iREN = '0; done = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Reference model state
    int m_busy, m_cls, m_own, m_dp, m_ip, m_st;

    function automatic int pick(logic [1:0] req, int ptr);
        for (int off = 0; off < N; off++) begin
            int c;
            c = (ptr + off) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [1:0] dr, input logic [1:0] dw, input logic [1:0] ir, input logic dn);
        logic [1:0] dq;
        int w;
        dq = dr | dw;
        if (m_busy == 0) begin
            if ((m_st == SM && ir != 0) || (dq == 0 && ir != 0)) begin
                w = pick(ir, m_ip);
                m_busy = 1; m_cls = 1; m_own = w; m_ip = (w + 1) % N; m_st = 0;
            end else if (dq != 0) begin
                w = pick(dq, m_dp);
                m_busy = 1; m_cls = 0; m_own = w; m_dp = (w + 1) % N;
                m_st = (ir != 0) ? ((m_st + 1 > SM) ? SM : m_st + 1) : 0;
            end
        end else begin
            logic own;
            own = (m_cls == 1) ? ir[m_own] : dq[m_own];
            if (dn || !own) m_busy = 0;
        end
    endtask

    initial begin
        // Directed table: inputs for one cycle, outputs expected after that edge
        tbl[0]  = mk(2'b11, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0);
        tbl[1]  = mk(2'b11, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
        tbl[2]  = mk(2'b11, 2'b00, 2'b00, 0, 2'b10, 2'b00, 1);
        tbl[3]  = mk(2'b11, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
        tbl[4]  = mk(2'b01, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0);
        tbl[5]  = mk(2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
        tbl[6]  = mk(2'b00, 2'b01, 2'b10, 0, 2'b01, 2'b00, 0);
        tbl[7]  = mk(2'b00, 2'b01, 2'b10, 1, 2'b00, 2'b00, 0);
        tbl[8]  = mk(2'b00, 2'b00, 2'b10, 0, 2'b00, 2'b10, 1);
        tbl[9]  = mk(2'b00, 2'b00, 2'b10, 1, 2'b00, 2'b00, 0);
        tbl[10] = mk(2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b00, 1);
        tbl[11] = mk(2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b00, 1);
        tbl[12] = mk(2'b01, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        tbl[13] = mk(2'b01, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0);
        tbl[14] = mk(2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
        tbl[15] = mk(2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);
        tbl[16] = mk(2'b11, 2'b00, 2'b01, 0, 2'b10, 2'b00, 1);
        tbl[17] = mk(2'b00, 2'b00, 2'b01, 1, 2'b00, 2'b00, 0);
        tbl[18] = mk(2'b00, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0);
        tbl[19] = mk(2'b00, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0);
        tbl[20] = mk(2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        tbl[21] = mk(2'b01, 2'b01, 2'b00, 0, 2'b01, 2'b00, 0);
        tbl[22] = mk(2'b00, 2'b01, 2'b00, 0, 2'b01, 2'b00, 0);
        tbl[23] = mk(2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0);

        // Reset with requests active: outputs clear without a clock
        nRST = 1'b0;
        dREN = 2'b11; dWEN = 2'b11; iREN = 2'b11; done = 1'b0;
        #1;
        expect_out("rst_async", 2'b00, 2'b00, 0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        @(negedge CLK);
        expect_out("rst_held", 2'b00, 2'b00, 0);
        nRST = 1'b1;
        cyc(2'b00, 2'b00, 2'b00, 0);
        cyc(2'b00, 2'b00, 2'b00, 0);
        expect_out("idle_noreq", 2'b00, 2'b00, 0);

        // Async reset in the middle of a data grant
        cyc(2'b11, 2'b00, 2'b00, 0);
        expect_out("pre_rst_grant", 2'b01, 2'b00, 0);
        #2 nRST = 1'b0;
        #1;
        expect_out("mid_rst_data", 2'b00, 2'b00, 0);
        chk("mid_rst_valid", 32'(grant_valid), 32'd0);
        dREN = '0;
        @(negedge CLK);
        nRST = 1'b1;

        // Directed table from a clean reset state
        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].dr, tbl[i].dw, tbl[i].ir, tbl[i].dn);
            expect_out($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ei, tbl[i].eid);
        end

        // Starvation: SM data wins against a held iREN, then instr is forced to win
        do_reset();
        for (int g = 0; g < SM; g++) begin
            cyc(2'b11, 2'b00, 2'b01, 0);
            expect_out($sformatf("starve_d%0d", g), (g % 2 == 0) ? 2'b01 : 2'b10, 2'b00, (g % 2 == 0) ? 1'b0 : 1'b1);
            cyc(2'b11, 2'b00, 2'b01, 0);
            cyc(2'b11, 2'b00, 2'b01, 0);
            cyc(2'b11, 2'b00, 2'b01, 1);
            expect_out($sformatf("starve_done%0d", g), 2'b00, 2'b00, 0);
        end
        cyc(2'b11, 2'b00, 2'b01, 0);
        expect_out("starve_instr", 2'b00, 2'b01, 0);
        cyc(2'b11, 2'b00, 2'b01, 0);
        expect_out("starve_hold", 2'b00, 2'b01, 0);
        cyc(2'b11, 2'b00, 2'b01, 1);
        cyc(2'b11, 2'b00, 2'b01, 0);
        expect_out("starve_cleared", 2'b01, 2'b00, 0);
        cyc(2'b00, 2'b00, 2'b00, 1);

        // Async reset mid instruction grant restores iptr to 0
        do_reset();
        cyc(2'b00, 2'b00, 2'b01, 0);
        expect_out("instr_g0", 2'b00, 2'b01, 0);
        #2 nRST = 1'b0;
        #1;
        expect_out("mid_rst_instr", 2'b00, 2'b00, 0);
        @(negedge CLK);
        nRST = 1'b1;
        cyc(2'b00, 2'b00, 2'b11, 0);
        expect_out("iptr_reset", 2'b00, 2'b01, 0);
        cyc(2'b00, 2'b00, 2'b11, 1);
        cyc(2'b00, 2'b00, 2'b10, 0);
        expect_out("instr_core1", 2'b00, 2'b10, 1);
        cyc(2'b00, 2'b00, 2'b10, 1);
        expect_out("instr_done", 2'b00, 2'b00, 0);

        // Randomized sticky requests against the reference model
        do_reset();
        m_busy = 0; m_cls = 0; m_own = 0; m_dp = 0; m_ip = 0; m_st = 0;
        begin
            logic [1:0] dr, dw, ir;
            logic       dn;
            logic [1:0] ed, ei;
            dr = '0; dw = '0; ir = '0;
            for (int t = 0; t < 600; t++) begin
                for (int k = 0; k < N; k++) begin
                    if ($urandom_range(0, 3) == 0) dr[k] = ~dr[k];
                    if ($urandom_range(0, 5) == 0) dw[k] = ~dw[k];
                    if ($urandom_range(0, 3) == 0) ir[k] = ~ir[k];
                end
                dn = ($urandom_range(0, 3) == 0);
                model_step(dr, dw, ir, dn);
                cyc(dr, dw, ir, dn);
                ed = (m_busy == 1 && m_cls == 0) ? 2'(1 << m_own) : 2'b00;
                ei = (m_busy == 1 && m_cls == 1) ? 2'(1 << m_own) : 2'b00;
                expect_out($sformatf("rnd%0d", t), ed, ei, (m_busy == 1) ? 1'(m_own) : 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
